// File: rtl/if_id_skid_pkg.sv
// Shared constants and helpers for the IF/ID skid stage and its pipe entries.
// Defaults match the core's NOP encoding and zero reset vector.
package if_id_skid_pkg;

  localparam int          REG_BUS_W   = 32;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic        ENABLE      = 1'b1;
  localparam logic        DISABLE     = 1'b0;
  localparam int          IF_ID_DEPTH = 2;

  function automatic logic [1:0] occ_count(input logic main_vld, input logic skid_vld);
    return {1'b0, main_vld} + {1'b0, skid_vld};
  endfunction

endpackage

// File: rtl/if_id_skid_pipe_entry.sv
// One {valid, inst, addr} pipeline register; flush beats load beats drop.
// Flush resets addr/inst, drop clears only valid so addr stays visible.
module pipe_entry
  import if_id_skid_pkg::*;
#(
  parameter int                INST_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(INST_NOP),
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    if (flush_i) begin
      valid_d = DISABLE;
      inst_d  = NOP_INST;
      addr_d  = RESET_ADDR;
    end else if (load_i) begin
      valid_d = ENABLE;
      inst_d  = inst_i;
      addr_d  = addr_i;
    end else if (drop_i) begin
      valid_d = DISABLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= DISABLE;
      inst_q  <= NOP_INST;
      addr_q  <= RESET_ADDR;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID 2-entry skid stage: 1-cycle in->out latency, 1 beat/cycle sustained.
// in_ready is a pure flop output (~skid valid); flush drops everything held.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                INST_W     = REG_BUS_W,
  parameter int                ADDR_W     = REG_BUS_W,
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(INST_NOP),
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(ZERO_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [INST_W-1:0] m_inst, s_inst;
  logic [ADDR_W-1:0] m_addr, s_addr;

  logic accept, drain;
  logic m_load, m_drop, s_load, s_drop;
  logic [INST_W-1:0] m_inst_src;
  logic [ADDR_W-1:0] m_addr_src;

  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;

  // Main refills from skid when it holds a beat (older), otherwise from fetch.
  assign m_load     = (~m_valid & accept) | (drain & (s_valid | accept));
  assign m_drop     = drain & ~m_load;
  assign m_inst_src = s_valid ? s_inst : in_inst;
  assign m_addr_src = s_valid ? s_addr : in_addr;

  assign s_load = m_valid & ~drain & accept;
  assign s_drop = drain & s_valid;

  pipe_entry #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .NOP_INST(NOP_INST), .RESET_ADDR(RESET_ADDR)
  ) u_main (
    .clk(clk), .rst(rst), .flush_i(flush), .load_i(m_load), .drop_i(m_drop),
    .inst_i(m_inst_src), .addr_i(m_addr_src),
    .valid_o(m_valid), .inst_o(m_inst), .addr_o(m_addr)
  );

  pipe_entry #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .NOP_INST(NOP_INST), .RESET_ADDR(RESET_ADDR)
  ) u_skid (
    .clk(clk), .rst(rst), .flush_i(flush), .load_i(s_load), .drop_i(s_drop),
    .inst_i(in_inst), .addr_i(in_addr),
    .valid_o(s_valid), .inst_o(s_inst), .addr_o(s_addr)
  );

  assign out_valid = m_valid;
  assign out_inst  = m_valid ? m_inst : NOP_INST;
  assign out_addr  = m_addr;
  assign occupancy = occ_count(m_valid, s_valid);

  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) !(s_valid && !m_valid));

endmodule

// File: tb/tb_if_id_skid.sv
// Randomised and directed bench for if_id_skid against a queue-based FIFO model.
module tb_if_id_skid;

  localparam int          IW  = 32;
  localparam int          AW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [IW-1:0] in_inst, out_inst;
  logic [AW-1:0] in_addr, out_addr;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  if_id_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] addr;
  } beat_t;

  beat_t         q[$];
  logic [AW-1:0] last_addr;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_taken = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_addr = '0;
  endtask

  task automatic check_outputs();
    chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("out_inst",  {32'd0, out_inst},  {32'd0, (q.size() > 0) ? q[0].inst : NOP});
    chk("out_addr",  {32'd0, out_addr},  {32'd0, (q.size() > 0) ? q[0].addr : last_addr});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
  endtask

  // Called at a negedge: drive, compare, cross one rising edge, update the model.
  task automatic step(input logic iv, input logic [IW-1:0] inst, input logic [AW-1:0] addr,
                      input logic ordy, input logic fl);
    logic acc, drn;
    in_valid  = iv;
    in_inst   = inst;
    in_addr   = addr;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    acc = iv && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (drn) begin
      last_addr = q[0].addr;
      void'(q.pop_front());
      n_taken++;
    end
    if (fl) begin
      q.delete();
      last_addr = '0;
    end else if (acc) begin
      q.push_back('{inst: inst, addr: addr});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst",  {32'd0, out_inst},  {32'd0, NOP});
    chk("rst_out_addr",  {32'd0, out_addr},  64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
  endtask

  initial begin
    int taken_before;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_addr = '0;
    model_reset();
    #12;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Streaming with decode always ready.
    step(1'b1, 32'hA, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hB, 32'h4, 1'b1, 1'b0);
    step(1'b1, 32'hC, 32'h8, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall fills skid, then release drains in order.
    step(1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h999, 32'h99, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush a full buffer while fetch offers addr 0x10.
    step(1'b1, 32'h200, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h34, 1'b0, 1'b0);
    step(1'b1, 32'h210, 32'h10, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush coinciding with a drain: beat taken once, then 0x20 flows normally.
    step(1'b1, 32'h300, 32'h40, 1'b0, 1'b0);
    taken_before = n_taken;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_drain_taken", 64'(n_taken - taken_before), 64'd1);
    step(1'b1, 32'h320, 32'h20, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with both entries held.
    step(1'b1, 32'h400, 32'h50, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'h54, 1'b0, 1'b0);
    chk("pre_rst_occupancy", {62'd0, occupancy}, 64'd2);
    in_valid = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Random traffic with back-pressure and occasional flush.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline stage for the hubulab RISC-V core.
- Replaces the fixed 32-bit hold/flush register with a 2-entry skid buffer and a valid/ready handshake on both sides.
- Lets fetch run at full rate while decode back-pressures without a combinational ready path.
- Flush (jump/branch redirect) kills all in-flight entries; decode sees a NOP bubble whenever no valid instruction is presented.

Parameters:
- INST_W, 32, instruction width in bits.
- ADDR_W, 32, PC/address width in bits.
- NOP_INST, 32'h0000_0013, encoding driven on out_inst when out_valid=0 (addi x0,x0,0).
- RESET_ADDR, {ADDR_W{1'b0}}, value of out_addr after reset and flush.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  redirect (jump/branch taken): discard all held and incoming beats.
- in_valid  in  1  fetch presents inst/addr.
- in_ready  out  1  stage can accept a beat; registered.
- in_inst  in  INST_W  fetched instruction.
- in_addr  in  ADDR_W  PC of fetched instruction.
- out_valid  out  1  decode-side beat valid.
- out_ready  in  1  decode accepts beat.
- out_inst  out  INST_W  instruction to decode; NOP_INST when out_valid=0.
- out_addr  out  ADDR_W  PC of out_inst; held at last value or RESET_ADDR when invalid.
- occupancy  out  2  entries held (0..2), for perf counters and the hazard unit.

Behaviour:
- Storage: main entry (m_valid, m_inst, m_addr) drives outputs; skid entry (s_valid, s_inst, s_addr) catches the beat accepted while main stalls.
- in_ready = ~s_valid (flop-derived only, no combinational path from out_ready).
- out_valid = m_valid. out_inst = m_valid ? m_inst : NOP_INST. out_addr = m_addr.
- Accept event A = in_valid & in_ready. Drain event D = m_valid & out_ready.
- Reset (async, rst=1): m_valid=s_valid=0, m_addr=s_addr=RESET_ADDR, inst regs=NOP_INST. Outputs: out_valid=0, out_inst=NOP_INST, out_addr=RESET_ADDR, in_ready=1, occupancy=0. Reset mid-transfer discards everything; no beat is reported accepted in the reset cycle.
- Flush (highest priority after reset): next edge m_valid=s_valid=0, m_addr=RESET_ADDR. A beat offered in the flush cycle counts as consumed (A may be 1) but is dropped. Flush with out_ready=1 in the same cycle: the drained beat is still considered taken by decode.
- Normal update, no flush, by state:
  - Empty (m=0, s=0): A loads main. Latency in->out = 1 cycle.
  - One (m=1, s=0): D&A loads main with the input. D only empties main. A only (stall) loads skid; in_ready falls next cycle. Neither holds.
  - Full (m=1, s=1): in_ready=0, so no A. D moves skid into main and clears skid. Otherwise hold.
- Ordering: strict FIFO; no beat duplicated or lost except by flush.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- occupancy = m_valid + s_valid (2-bit add). State s=1 with m=0 is illegal; an assertion checks it never occurs.
- Width rules: all data paths are pure moves, no arithmetic beyond occupancy.

Decomposition:
- defines.v holds INST_NOP, ZeroWord, RegBus width and the Enable/Disable constants; NOP_INST and RESET_ADDR default to these.
- Add `define IF_ID_DEPTH 2 for perf-counter sizing.
- One natural sub-module: pipe_entry, an {valid, inst, addr} register with load/clear inputs and async active-high reset. It is instantiated twice (main, skid) and is reusable for id_ex.

Test Plan:
- Reset: assert rst mid-stream with 2 entries held -> same cycle out_valid=0, out_inst=32'h13, out_addr=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, feed addr 0x0,0x4,0x8 with inst 0xA,0xB,0xC back-to-back -> each appears 1 cycle later in order, in_ready stays 1, occupancy stays 1.
- Stall/skid: out_ready=0 while offering 0x0 then 0x4 -> occupancy=2, in_ready=0. Release out_ready -> 0x0 then 0x4 out on consecutive cycles, in_ready returns 1 the cycle after skid drains.
- Flush full buffer: occupancy=2 plus flush with in_valid=1 at addr 0x10 -> next cycle out_valid=0, out_inst=NOP, out_addr=0, occupancy=0. 0x10 never appears at the output.
- Flush plus drain: m_valid=1, out_ready=1, flush=1 -> beat is consumed exactly once and output is empty next cycle. Next input 0x20 appears 1 cycle after acceptance.
- Random back-pressure: 1000 random in_valid/out_ready/flush cycles against a scoreboard model -> no reordering, loss only on flush, s_valid&~m_valid never true.
